// File: rtl/down_cntr_tc.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : down_cntr_tc
// Purpose  : Prescaled, loadable, synchronous down counter with a one-cycle
//            terminal-count pulse. A single clock is used throughout; the
//            prescaler produces an internal tick enable instead of a derived
//            clock. Supports one-shot and auto-reload operation.
// Revision : 1.0 - initial release
// ============================================================================
module down_cntr_tc #(
  parameter int WIDTH = 4,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             busy
);

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Prescaler width; a DIV of 1 needs no prescaler storage at all.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             tc_q, tc_d;
  logic             run;
  logic             tick;

  assign run = (state_q == ST_RUN);

  // --------------------------------------------------------------------------
  // Prescaler: advances only while RUN, wraps on tick, cleared by load.
  // PAUSE holds it so a paused count resumes exactly where it stopped.
  // --------------------------------------------------------------------------
  generate
    if (DIV == 1) begin : g_presc_div1
      assign tick = run;
    end else begin : g_presc_divn
      localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
      logic [PW-1:0] presc_q, presc_d;

      assign tick = run && (presc_q == PRESC_MAX);

      // Next prescaler value: load clears, RUN advances/wraps, else hold
      always_comb begin
        presc_d = presc_q;
        if (ld) begin
          presc_d = '0;
        end else if (run) begin
          presc_d = tick ? '0 : presc_q + PW'(1);
        end
      end

      // Prescaler register with asynchronous clear
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_d;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic. Load has top priority and suppresses any tick on the
  // same edge. tc defaults low so it is exactly one cycle wide.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rl_d    = rl_q;
    tc_d    = 1'b0;

    if (ld) begin
      cnt_d = d;
      rl_d  = d;
      if (d == '0) begin
        state_d = ST_DONE;
      end else if (en) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_PAUSE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          // A RUN edge with en low still counts; only later edges freeze.
          state_d = en ? ST_RUN : ST_PAUSE;
          if (tick) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
              tc_d = 1'b1;
              if (reload) begin
                cnt_d = rl_q;
              end else begin
                cnt_d   = '0;
                state_d = ST_DONE;
              end
            end else begin
              // Zero in RUN is unreachable; park safely without wrapping.
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (en) begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE,
        ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Main state, count, reload and tc registers with asynchronous clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rl_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rl_q    <= rl_d;
      tc_q    <= tc_d;
    end
  end

  // Outputs come straight from registers (qb is a pure inversion of q)
  assign q    = cnt_q;
  assign qb   = ~cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_down_cntr_tc.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_down_cntr_tc
// Purpose  : Directed self-checking bench for down_cntr_tc (WIDTH=4, DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_cntr_tc;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;

  logic             clk;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             busy;

  int n_checks;
  int n_errors;

  down_cntr_tc #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .ld     (ld),
    .d      (d),
    .en     (en),
    .reload (reload),
    .q      (q),
    .qb     (qb),
    .tc     (tc),
    .busy   (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load d with the given enable/reload, consuming one edge (edge +0)
  task automatic do_load(input logic [WIDTH-1:0] val, input logic e, input logic r);
    d      = val;
    en     = e;
    reload = r;
    ld     = 1'b1;
    step(1);
    ld     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr    = 1'b0;
    ld     = 1'b0;
    d      = '0;
    en     = 1'b0;
    reload = 1'b0;

    // ---------------- 1. Reset ----------------
    #12;
    check_eq("rst_q",    32'(q),    32'h0);
    check_eq("rst_qb",   32'(qb),   32'hF);
    check_eq("rst_tc",   32'(tc),   32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    step(1);
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = ~en;
      step(1);
    end
    check_eq("idle_q",    32'(q),    32'h0);
    check_eq("idle_busy", 32'(busy), 32'h0);
    check_eq("idle_tc",   32'(tc),   32'h0);

    // ---------------- 2. One-shot d=3 ----------------
    do_load(4'd3, 1'b1, 1'b0);
    check_eq("os_q0",    32'(q),    32'h3);
    check_eq("os_busy0", 32'(busy), 32'h1);
    check_eq("os_tc0",   32'(tc),   32'h0);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check_eq("os_q",    32'(q),    (k >= 12) ? 32'h0 : 32'(3 - k / 4));
      check_eq("os_tc",   32'(tc),   (k == 12) ? 32'h1 : 32'h0);
      check_eq("os_busy", 32'(busy), (k < 12)  ? 32'h1 : 32'h0);
    end
    // DONE ignores en
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(3);
    check_eq("done_q",  32'(q),  32'h0);
    check_eq("done_qb", 32'(qb), 32'hF);

    // ---------------- 3. Pause d=5 ----------------
    do_load(4'd5, 1'b1, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      en = !((k >= 3) && (k <= 12));
      step(1);
      check_eq("pz_q",  32'(q),  (k < 14) ? 32'h5 : 32'(4 - (k - 14) / 4));
      check_eq("pz_tc", 32'(tc), (k == 30) ? 32'h1 : 32'h0);
      if (k == 8)  check_eq("pz_busy_pause", 32'(busy), 32'h1);
      if (k == 31) check_eq("pz_busy_end",   32'(busy), 32'h0);
    end

    // ---------------- 4. Auto-reload d=2 ----------------
    do_load(4'd2, 1'b1, 1'b1);
    check_eq("ar_q0", 32'(q), 32'h2);
    for (int k = 1; k <= 31; k++) begin
      step(1);
      check_eq("ar_q",    32'(q),    ((k % 8) < 4) ? 32'h2 : 32'h1);
      check_eq("ar_tc",   32'(tc),   ((k % 8) == 0) ? 32'h1 : 32'h0);
      check_eq("ar_busy", 32'(busy), 32'h1);
    end

    // ---------------- 5. Collision: ld on tick edge with q=1 ----------------
    check_eq("col_pre_q", 32'(q), 32'h1);
    do_load(4'd7, 1'b1, 1'b1);
    check_eq("col_q",  32'(q),  32'h7);
    check_eq("col_qb", 32'(qb), 32'h8);
    check_eq("col_tc", 32'(tc), 32'h0);
    step(5);
    check_eq("mid_q", 32'(q), 32'h6);
    // Asynchronous clear between edges
    #3;
    clr = 1'b0;
    #1;
    check_eq("arst_q",    32'(q),    32'h0);
    check_eq("arst_qb",   32'(qb),   32'hF);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_tc",   32'(tc),   32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check_eq("arst_hold_tc", 32'(tc), 32'h0);
      check_eq("arst_hold_q",  32'(q),  32'h0);
    end
    clr = 1'b1;
    step(1);

    // ---------------- 6. Zero load ----------------
    do_load(4'd0, 1'b1, 1'b0);
    check_eq("z_q",    32'(q),    32'h0);
    check_eq("z_qb",   32'(qb),   32'hF);
    check_eq("z_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check_eq("z_tc",      32'(tc),   32'h0);
      check_eq("z_busy_hd", 32'(busy), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
